// File: rtl/square4s_pkg.sv
// Shared types and constants for the square4s sequential squarer.
// Build option: define SQUARE4S_RADIX4_EN to retire two multiplier bits per RUN cycle.
package square4s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF = 4;

  // Number of RUN iterations needed to consume an n-bit multiplier.
  function automatic int iter_count(input int n);
`ifdef SQUARE4S_RADIX4_EN
    return n / 2;
`else
    return n;
`endif
  endfunction

endpackage

// File: rtl/square4s_step.sv
// One shift-add iteration of the squarer: picks the addend from the low multiplier bit(s),
// adds it at the current weight, and advances multiplier and count (SQUARE4S_RADIX4_EN selects radix-4).
module square4s_step #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic [N-1:0]   i_mcand,
  input  logic [N-1:0]   i_mplier,
  input  logic [CW-1:0]  i_count,
  input  logic [2*N-1:0] i_acc,
  output logic [2*N-1:0] o_acc,
  output logic [N-1:0]   o_mplier,
  output logic [CW-1:0]  o_count
);

  logic [2*N-1:0] w_mcand;
  logic [2*N-1:0] w_addend;

  assign w_mcand = {{N{1'b0}}, i_mcand};

`ifdef SQUARE4S_RADIX4_EN
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_addend = '0;
    unique case (i_mplier[1:0])
      2'd1:    w_addend = w_mcand;
      2'd2:    w_addend = w_mcand << 1;
      2'd3:    w_addend = (w_mcand << 1) + w_mcand;
      default: w_addend = '0;
    endcase
  end

  assign o_mplier = i_mplier >> 2;
  assign o_count  = i_count + CW'(2);
`else
  assign w_addend = i_mplier[0] ? w_mcand : '0;
  assign o_mplier = i_mplier >> 1;
  assign o_count  = i_count + CW'(1);
`endif

  assign o_acc = i_acc + (w_addend << i_count);

endmodule

// File: rtl/square4s.sv
// Sequential unsigned squarer p = u*u: IDLE/RUN/DONE control plus operand and result registers.
// Build option SQUARE4S_RADIX4_EN halves the iteration count; the interface is unchanged.
module square4s
  import square4s_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   u,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N + 1);
  // The shift amount advances by the bits retired per iteration, so it reaches N when finished.
  localparam logic [CW-1:0] C_LAST = CW'((N / iter_count(N)) * iter_count(N));

  state_t         r_state;
  logic [N-1:0]   r_mcand;
  logic [N-1:0]   r_mplier;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_p;
  logic [CW-1:0]  r_count;

  logic [2*N-1:0] w_acc_next;
  logic [N-1:0]   w_mplier_next;
  logic [CW-1:0]  w_count_next;

  square4s_step #(.N(N), .CW(CW)) u_step (
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .i_count  (r_count),
    .i_acc    (r_acc),
    .o_acc    (w_acc_next),
    .o_mplier (w_mplier_next),
    .o_count  (w_count_next)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_p      <= '0;
      r_count  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= u;
            r_mplier <= u;
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (r_count == C_LAST) begin
            r_p     <= r_acc;
            r_state <= DONE;
          end else begin
            r_acc    <= w_acc_next;
            r_mplier <= w_mplier_next;
            r_count  <= w_count_next;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready = (r_state == IDLE);
  assign done  = (r_state == DONE);
  assign p     = r_p;

endmodule

// File: tb/tb_square4s.sv
// Self-checking bench for square4s: directed cases plus $urandom operands against an
// arithmetic model (p = u*u, fixed latency); builds with or without SQUARE4S_RADIX4_EN.
module tb_square4s;

  localparam int N = 4;
`ifdef SQUARE4S_RADIX4_EN
  localparam int LAT = N / 2 + 1;
`else
  localparam int LAT = N + 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   u = '0;
  logic           ready;
  logic           done;
  logic [2*N-1:0] p;

  int             n_cmp = 0;
  int             n_err = 0;
  logic [2*N-1:0] exp_p = '0;

  square4s #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .u     (u),
    .ready (ready),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One squaring; noisy keeps start and u toggling randomly after the capture edge.
  task automatic run_op(input logic [N-1:0] val, input bit noisy);
    @(negedge clk);
    check("ready_before_start", {15'd0, ready}, 16'd1);
    start = 1'b1;
    u     = val;
    @(posedge clk);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      u     = N'($urandom);
      start = noisy ? 1'($urandom) : 1'b0;
      @(posedge clk);
      #1;
      if (k < LAT) begin
        check("run_done_low", {15'd0, done}, 16'd0);
        check("run_ready_low", {15'd0, ready}, 16'd0);
        check("run_p_hold", 16'(p), 16'(exp_p));
      end else if (k == LAT) begin
        exp_p = (2*N)'(int'(val) * int'(val));
        check("done_pulse", {15'd0, done}, 16'd1);
        check("done_ready_low", {15'd0, ready}, 16'd0);
        check("result_p", 16'(p), 16'(exp_p));
      end else begin
        check("after_done_low", {15'd0, done}, 16'd0);
        check("after_ready_high", {15'd0, ready}, 16'd1);
        check("after_p_hold", 16'(p), 16'(exp_p));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset state, including across clock edges while held.
    #1;
    check("rst_ready", {15'd0, ready}, 16'd1);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_p", 16'(p), 16'd0);
    start = 1'b1;
    u     = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    check("rst_held_ready", {15'd0, ready}, 16'd1);
    check("rst_held_p", 16'(p), 16'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;

    // Max operand, then zero followed by 8 at the earliest accepted start.
    run_op(4'd15, 1'b0);
    run_op(4'd0, 1'b0);
    run_op(4'd8, 1'b0);

    // Start hammered and u toggling while busy.
    for (int i = 0; i < 6; i++) run_op(N'($urandom), 1'b1);

    // Reset raised at t0+2 during u=9 aborts the operation.
    @(negedge clk);
    start = 1'b1;
    u     = 4'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_p = '0;
    check("abort_ready", {15'd0, ready}, 16'd1);
    check("abort_done", {15'd0, done}, 16'd0);
    check("abort_p", 16'(p), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", {15'd0, done}, 16'd0);
    end
    run_op(4'd9, 1'b0);

    // Exhaustive operands, alternating quiet and noisy inputs.
    for (int v = 0; v < 16; v++) run_op(N'(v), v[0]);

    // Random operands.
    for (int i = 0; i < 20; i++) run_op(N'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
